// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the CPU and a DMA/loader
// master. One request is latched at a time and walked through IDLE -> ACCESS -> DONE, so each
// access takes three cycles and ends with a one-cycle ack to its owner. CPU wins ties unless it
// has already taken STARVE_MAX grants in a row while DMA was waiting.
// Optional feature: define MEM_ARB_PROTECT_EN to block DMA writes into the instruction region
// (word index < INST_WORDS); blocked writes still complete, with dma_err pulsed alongside dma_ack.
module mem_port_arbiter #(
  parameter int RAM_SIZE_BIT = 8,
  parameter int INST_WORDS   = 32,
  parameter int STARVE_MAX   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_W = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  streak_q, streak_d;
  logic           own_dma_q, own_dma_d;
  logic           we_q, we_d;
  logic           blocked_q, blocked_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    cpu_rdata_q, cpu_rdata_d;
  logic [31:0]    dma_rdata_q, dma_rdata_d;
  logic           grant_dma_s;
  logic           protect_hit_s;

`ifdef MEM_ARB_PROTECT_EN
  localparam logic [31:0] INST_WORDS_W = 32'(INST_WORDS);
  logic [RAM_SIZE_BIT-1:0] dma_widx_s;
  assign dma_widx_s    = dma_addr[RAM_SIZE_BIT+1:2];
  // A DMA address hits protection when its word index lands in the instruction region.
  assign protect_hit_s = ({{(32-RAM_SIZE_BIT){1'b0}}, dma_widx_s} < INST_WORDS_W);
`else
  assign protect_hit_s = 1'b0;
`endif

  // State register plus latched request and per-master read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      streak_q    <= '0;
      own_dma_q   <= 1'b0;
      we_q        <= 1'b0;
      blocked_q   <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      cpu_rdata_q <= 32'd0;
      dma_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      own_dma_q   <= own_dma_d;
      we_q        <= we_d;
      blocked_q   <= blocked_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  // Next-state: arbitration and request latching in IDLE, read capture at the end of ACCESS.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    own_dma_d   = own_dma_q;
    we_d        = we_q;
    blocked_d   = blocked_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    grant_dma_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dma_req) begin
          // DMA wins alone, or when the CPU streak has reached its limit.
          grant_dma_s = dma_req && (!cpu_req || (streak_q == STARVE_W));
          own_dma_d   = grant_dma_s;
          we_d        = grant_dma_s ? dma_we    : cpu_we;
          addr_d      = grant_dma_s ? dma_addr  : cpu_addr;
          wdata_d     = grant_dma_s ? dma_wdata : cpu_wdata;
          blocked_d   = grant_dma_s && dma_we && protect_hit_s;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
        // Streak counts CPU grants made while DMA waits; any idle-without-DMA clears it.
        if (grant_dma_s || !dma_req) begin
          streak_d = '0;
        end else if (cpu_req && (streak_q != STARVE_W)) begin
          streak_d = streak_q + SW'(1);
        end else begin
          streak_d = streak_q;
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          if (own_dma_q) begin
            dma_rdata_d = mem_rdata;
          end else begin
            cpu_rdata_d = mem_rdata;
          end
        end else begin
          cpu_rdata_d = cpu_rdata_q;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory strobes decode from the state register only, so a reset drops them at once.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state_q == ST_ACCESS) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_read  = !we_q && !blocked_q;
      mem_write = we_q && !blocked_q;
    end else begin
      mem_addr  = 32'd0;
    end
  end

  assign cpu_ack   = (state_q == ST_DONE) && !own_dma_q;
  assign dma_ack   = (state_q == ST_DONE) && own_dma_q;
`ifdef MEM_ARB_PROTECT_EN
  assign dma_err   = (state_q == ST_DONE) && own_dma_q && blocked_q;
`else
  assign dma_err   = 1'b0;
`endif
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural word memory attached to the mem_* pins.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_ack, dma_ack, dma_err, mem_read, mem_write, busy;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

`ifdef MEM_ARB_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];

  // Behavioural memory: commits on the rising edge while MemWrite is high.
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int n_checks = 0;
  int n_fails  = 0;
  logic [33:0] cpu_q[$];
  logic [33:0] dma_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor: every ack pops one expected entry {err, is_read, data}.
  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (cpu_ack) begin
      check_val("cpu_ack_pending", {31'd0, cpu_q.size() != 0}, 32'd1);
      if (cpu_q.size() != 0) begin
        e = cpu_q.pop_front();
        if (e[32]) check_val("cpu_rdata", cpu_rdata, e[31:0]);
      end
    end
    if (dma_ack) begin
      check_val("dma_ack_pending", {31'd0, dma_q.size() != 0}, 32'd1);
      if (dma_q.size() != 0) begin
        e = dma_q.pop_front();
        check_val("dma_err", {31'd0, dma_err}, {31'd0, e[33]});
        if (e[32]) check_val("dma_rdata", dma_rdata, e[31:0]);
      end
    end
  end

  task automatic single_access(input bit is_dma, input bit we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    int idx;
    bit blk;
    idx = int'(addr[9:2]);
    blk = PROT && is_dma && we && (idx < 32);
    @(negedge clk);
    if (is_dma) begin
      dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
    if (we) begin
      if (!blk) ref_mem[idx] = wdata;
      if (is_dma) dma_q.push_back({blk, 1'b0, wdata});
      else        cpu_q.push_back({1'b0, 1'b0, wdata});
    end else begin
      if (is_dma) dma_q.push_back({1'b0, 1'b1, ref_mem[idx]});
      else        cpu_q.push_back({1'b0, 1'b1, ref_mem[idx]});
    end
    @(negedge clk);
    check_val("acc_mem_read",  {31'd0, mem_read},  {31'd0, !we && !blk});
    check_val("acc_mem_write", {31'd0, mem_write}, {31'd0, we && !blk});
    check_val("acc_mem_addr",  mem_addr, addr);
    check_val("acc_mem_wdata", mem_wdata, wdata);
    check_val("acc_busy",      {31'd0, busy}, 32'd1);
    @(negedge clk);
    check_val("done_acks", {30'd0, cpu_ack, dma_ack}, is_dma ? 32'd1 : 32'd2);
    check_val("done_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    check_val("idle_after", {27'd0, busy, mem_read, mem_write, cpu_ack, dma_ack}, 32'd0);
    check_val("idle_addr", mem_addr, 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    string exp_order;
    string got;
    int n;
    int cyc;
    logic [7:0] g;
    logic [7:0] ex;
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'd0; dma_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'hA500_0000 ^ (i * 32'h0101_0101);
      ref_mem[i] = 32'hA500_0000 ^ (i * 32'h0101_0101);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_flags", {26'd0, busy, mem_read, mem_write, cpu_ack, dma_ack, dma_err}, 32'd0);
    check_val("rst_mem_addr", mem_addr, 32'd0);
    check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
    reset = 1'b1;

    // Idle for 10 cycles with no requests
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_val("idle_noreq", {26'd0, busy, mem_read, mem_write, cpu_ack, dma_ack, dma_err}, 32'd0);
    end

    // CPU read of word 1
    single_access(1'b0, 1'b0, 32'h0000_0004, 32'd0);
    check_val("cpu_rd_word1", cpu_rdata, 32'hA500_0000 ^ 32'h0101_0101);

    // DMA write then CPU read-back; CPU write and DMA read leave cpu_rdata alone
    single_access(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF);
    single_access(1'b0, 1'b0, 32'h0000_0200, 32'h1111_2222);
    check_val("cpu_rd_dma_data", cpu_rdata, 32'hDEAD_BEEF);
    single_access(1'b0, 1'b1, 32'h0000_0204, 32'h5555_AAAA);
    single_access(1'b1, 1'b0, 32'h0000_0204, 32'd0);
    check_val("cpu_rdata_held", cpu_rdata, 32'hDEAD_BEEF);
    check_val("dma_rd_cpu_data", dma_rdata, 32'h5555_AAAA);

    // Mixed traffic with random byte offsets
    for (int i = 0; i < 8; i++) begin
      single_access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {22'd0, 8'($urandom_range(32, 255)), 2'($urandom_range(0, 3))}, $urandom);
    end

    // Both masters requesting continuously
    exp_order = "CCCCDCCCCD";
    got = "";
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0300;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0000_0304;
    for (int i = 0; i < 8; i++) cpu_q.push_back({2'b01, ref_mem[192]});
    for (int i = 0; i < 2; i++) dma_q.push_back({2'b01, ref_mem[193]});
    n = 0;
    cyc = 0;
    while (n < 10 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cpu_ack) begin got = {got, "C"}; n++; end
      if (dma_ack) begin got = {got, "D"}; n++; end
    end
    cpu_req = 1'b0;
    dma_req = 1'b0;
    check_val("grant_count", n, 32'd10);
    for (int i = 0; i < 10; i++) begin
      g  = (i < got.len()) ? got[i] : 8'h3F;
      ex = exp_order[i];
      check_val("grant_order", {24'd0, g}, {24'd0, ex});
    end
    @(negedge clk);

`ifdef MEM_ARB_PROTECT_EN
    // Protected instruction region
    single_access(1'b1, 1'b1, 32'h0000_0010, 32'hBAD0_BAD0);
    single_access(1'b1, 1'b0, 32'h0000_0010, 32'd0);
    single_access(1'b1, 1'b1, 32'h0000_0100, 32'h0F0F_0F0F);
    single_access(1'b0, 1'b0, 32'h0000_0100, 32'd0);
    check_val("prot_commit", cpu_rdata, 32'h0F0F_0F0F);
`endif

    // Reset in the middle of a CPU write
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0240; cpu_wdata = 32'h1234_5678;
    @(negedge clk);
    check_val("rstw_access", {31'd0, mem_write}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check_val("rstw_mem_write", {31'd0, mem_write}, 32'd0);
    check_val("rstw_busy", {31'd0, busy}, 32'd0);
    check_val("rstw_addr", mem_addr, 32'd0);
    @(negedge clk);
    check_val("rstw_no_ack", {30'd0, cpu_ack, dma_ack}, 32'd0);
    check_val("rstw_no_commit", mem[144], ref_mem[144]);
    check_val("rstw_rdata_clr", cpu_rdata, 32'd0);
    cpu_req = 1'b0;
    reset = 1'b1;
    single_access(1'b0, 1'b0, 32'h0000_0240, 32'd0);

    repeat (2) @(negedge clk);
    check_val("cpu_q_empty", cpu_q.size(), 32'd0);
    check_val("dma_q_empty", dma_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
